// File: rtl/simon_sequencer.sv
// simon_sequencer: pattern side of the Simon game - grows an LFSR-derived sequence, plays it on the LEDs,
// then feeds expected patterns to equality_check. Optional macro SIMON_FREE_RUN_SEED_EN free-runs the LFSR while idle.
//
// state        | meaning
// S_IDLE       | after reset, waiting for start
// S_SHOW       | lighting mem[idx] for DISPLAY_CYCLES
// S_GAP        | dark between patterns
// S_WAIT_INPUT | presenting mem[idx] to equality_check, waiting for a press
// S_GROW       | round complete: extend the sequence or declare a win
// S_PAUSE      | dark before replaying the grown sequence
// S_LOSE       | wrong entry, all LEDs lit until start
// S_WIN        | MAX_LEN reached, alternating LEDs until start
module simon_sequencer #(
    parameter int         MAX_LEN        = 16,
    parameter int         DISPLAY_CYCLES = 25_000_000,
    parameter int         GAP_CYCLES     = 12_500_000,
    parameter logic [7:0] SEED           = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       input_done,
    input  logic       input_correct,
    output logic [5:0] number_desired,
    output logic [5:0] led_pattern,
    output logic       expecting_input,
    output logic [5:0] level,
    output logic       game_over,
    output logic       game_won
);

    localparam int TMAX = (DISPLAY_CYCLES > GAP_CYCLES) ? DISPLAY_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [TW-1:0] T_SHOW  = TW'(DISPLAY_CYCLES);
    localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [5:0]    LEN_MAX = 6'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_SHOW, S_GAP, S_WAIT_INPUT, S_GROW, S_PAUSE, S_LOSE, S_WIN
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d, lfsr_nx;
    logic [5:0]    len_q, len_d, idx_q, idx_d, last_idx;
    logic [TW-1:0] timer_q, timer_d;
    logic          done_dly_q, press;
    logic [5:0]    mem_q [MAX_LEN];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [5:0]    new_elem;

    logic [5:0]    led_q, led_d, nd_q, nd_d, level_q;
    logic          exp_q, over_q, won_q;

    assign lfsr_nx  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign new_elem = (lfsr_nx[5:0] == 6'h00) ? 6'h01 : lfsr_nx[5:0];
    assign press    = input_done & ~done_dly_q;
    assign last_idx = len_q - 6'd1;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        led_d   = 6'h00;

        case (state_q)
            S_IDLE, S_LOSE, S_WIN: begin
`ifdef SIMON_FREE_RUN_SEED_EN
                lfsr_d = lfsr_nx;
`endif
                if (start) begin
                    lfsr_d  = lfsr_nx;
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    len_d   = 6'd1;
                    idx_d   = 6'd0;
                    timer_d = T_SHOW;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                // First SHOW cycle is dark; LEDs light from the cycle after entry.
                if (timer_q == '0) begin
                    timer_d = T_GAP;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q - T_ONE;
                    led_d   = mem_q[idx_q[AW-1:0]];
                end
            end
            S_GAP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - T_ONE;
                end else if (idx_q == last_idx) begin
                    idx_d   = 6'd0;
                    state_d = S_WAIT_INPUT;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    timer_d = T_SHOW;
                    state_d = S_SHOW;
                end
            end
            S_WAIT_INPUT: begin
                if (press) begin
                    if (!input_correct)          state_d = S_LOSE;
                    else if (idx_q == last_idx)  state_d = S_GROW;
                    else                         idx_d   = idx_q + 6'd1;
                end
            end
            S_GROW: begin
                if (len_q == LEN_MAX) begin
                    state_d = S_WIN;
                end else begin
                    lfsr_d  = lfsr_nx;
                    wr_en   = 1'b1;
                    wr_addr = len_q[AW-1:0];
                    len_d   = len_q + 6'd1;
                    idx_d   = 6'd0;
                    timer_d = T_GAP;
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (timer_q == '0) begin
                    timer_d = T_SHOW;
                    state_d = S_SHOW;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_LOSE)     led_d = 6'h3F;
        else if (state_d == S_WIN) led_d = 6'h2A;

        // mem is never written in a cycle that enters WAIT_INPUT, so the current array is safe to read.
        nd_d = (state_d == S_WAIT_INPUT) ? mem_q[idx_d[AW-1:0]] : nd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED;
            len_q      <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            done_dly_q <= 1'b0;
            led_q      <= '0;
            nd_q       <= '0;
            exp_q      <= 1'b0;
            level_q    <= '0;
            over_q     <= 1'b0;
            won_q      <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            done_dly_q <= input_done;
            led_q      <= led_d;
            nd_q       <= nd_d;
            exp_q      <= (state_d == S_WAIT_INPUT);
            level_q    <= len_d;
            over_q     <= (state_d == S_LOSE);
            won_q      <= (state_d == S_WIN);
            if (wr_en) mem_q[wr_addr] <= new_elem;
        end
    end

    assign number_desired  = nd_q;
    assign led_pattern     = led_q;
    assign expecting_input = exp_q;
    assign level           = level_q;
    assign game_over       = over_q;
    assign game_won        = won_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Testbench for simon_sequencer: directed steps plus randomized games checked against a sequence-level model.
module tb_simon_sequencer;

    localparam int         MAX_LEN = 3;
    localparam int         DISP    = 4;
    localparam int         GAP     = 2;
    localparam logic [7:0] SEED    = 8'hA5;
    localparam int         SLOT    = 1 + DISP + GAP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       input_done = 1'b0;
    logic       input_correct = 1'b0;
    logic [5:0] number_desired, led_pattern, level;
    logic       expecting_input, game_over, game_won;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] m_lfsr;
    logic [5:0] m_seq[$];
    logic [5:0] m_nd;

    always #5 clk = ~clk;

    simon_sequencer #(
        .MAX_LEN(MAX_LEN), .DISPLAY_CYCLES(DISP), .GAP_CYCLES(GAP), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .input_done(input_done), .input_correct(input_correct),
        .number_desired(number_desired), .led_pattern(led_pattern),
        .expecting_input(expecting_input), .level(level),
        .game_over(game_over), .game_won(game_won)
    );

    task automatic check6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Next pseudo-random element: shift left, feedback = parity of taps 7,5,4,3; all-dark becomes 1.
    task automatic model_gen();
        logic [7:0] nx;
        logic [5:0] e;
        nx = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        m_lfsr = nx;
        e = nx[5:0];
        if (e == 6'h00) e = 6'h01;
        m_seq.push_back(e);
    endtask

    // Each element occupies one slot: 1 dark entry cycle, DISP lit cycles, GAP dark cycles.
    task automatic play_check(input int start_at, input bit hold_end);
        int         total;
        logic [5:0] exp_led;
        total = SLOT * m_seq.size();
        for (int j = 0; j < total; j++) begin
            if ((j % SLOT) >= 1 && (j % SLOT) <= DISP) exp_led = m_seq[j / SLOT];
            else exp_led = 6'h00;
            check6("play_led", led_pattern, exp_led);
            check1("play_expecting", expecting_input, 1'b0);
            check6("play_level", level, 6'(m_seq.size()));
            check6("play_nd_hold", number_desired, m_nd);
            check1("play_over", game_over, 1'b0);
            check1("play_won", game_won, 1'b0);
            if (j == start_at) start = 1'b1;
            if (hold_end && j == total - 2) begin
                input_done = 1'b1;
                input_correct = 1'b0;
            end
            tick();
            start = 1'b0;
        end
        m_nd = m_seq[0];
        check1("wait_expecting", expecting_input, 1'b1);
        check6("wait_nd", number_desired, m_nd);
    endtask

    task automatic press(input bit ok);
        int gap;
        gap = $urandom_range(0, 3);
        repeat (gap) begin
            check1("wait_idle_expecting", expecting_input, 1'b1);
            check6("wait_idle_nd", number_desired, m_nd);
            tick();
        end
        input_done = 1'b1;
        input_correct = ok;
        tick();
    endtask

    task automatic run_game(input int fail_round, input int fail_step, input int start_at, input int hold_round);
        int hold;
        bit ok;
        repeat ($urandom_range(0, 4)) tick();
        start = 1'b1;
        m_seq.delete();
        model_gen();
        tick();
        start = 1'b0;
        for (int n = 1; n <= MAX_LEN; n++) begin
            play_check((n == 1) ? start_at : -1, hold_round == n);
            if (hold_round == n) begin
                repeat (2) begin
                    check1("held_expecting", expecting_input, 1'b1);
                    check6("held_nd", number_desired, m_nd);
                    check1("held_over", game_over, 1'b0);
                    tick();
                end
                input_done = 1'b0;
                tick();
            end
            for (int k = 0; k < n; k++) begin
                ok = !(n == fail_round && k == fail_step);
                press(ok);
                if (!ok) begin
                    input_done = 1'b0;
                    check1("lose_over", game_over, 1'b1);
                    check6("lose_led", led_pattern, 6'h3F);
                    check1("lose_expecting", expecting_input, 1'b0);
                    check6("lose_level", level, 6'(n));
                    check6("lose_nd_hold", number_desired, m_nd);
                    tick();
                    repeat (3) begin
                        input_done = 1'b1;
                        input_correct = 1'($urandom_range(0, 1));
                        tick();
                        input_done = 1'b0;
                        tick();
                        check1("lose_sticky_over", game_over, 1'b1);
                        check6("lose_sticky_led", led_pattern, 6'h3F);
                        check1("lose_sticky_expecting", expecting_input, 1'b0);
                    end
                    return;
                end
                if (k < n - 1) begin
                    m_nd = m_seq[k + 1];
                    hold = $urandom_range(0, 2);
                    for (int h = 0; h <= hold; h++) begin
                        check1("step_expecting", expecting_input, 1'b1);
                        check6("step_nd", number_desired, m_nd);
                        if (h == hold) input_done = 1'b0;
                        tick();
                    end
                end else begin
                    input_done = 1'b0;
                    check6("grow_led", led_pattern, 6'h00);
                    check1("grow_expecting", expecting_input, 1'b0);
                    check6("grow_level", level, 6'(n));
                    check6("grow_nd_hold", number_desired, m_nd);
                    tick();
                    if (n == MAX_LEN) begin
                        check1("win_won", game_won, 1'b1);
                        check6("win_led", led_pattern, 6'h2A);
                        check6("win_level", level, 6'(MAX_LEN));
                        check1("win_over", game_over, 1'b0);
                        return;
                    end
                    model_gen();
                    check6("pause_level", level, 6'(n + 1));
                    check6("pause_led", led_pattern, 6'h00);
                    tick();
                    check6("pause2_led", led_pattern, 6'h00);
                    check1("pause2_expecting", expecting_input, 1'b0);
                    tick();
                end
            end
        end
    endtask

    initial begin
        int fr, fs, sa, hr;
        rst_n = 1'b0;
        repeat (2) tick();
        check6("rst_led", led_pattern, 6'h00);
        check6("rst_nd", number_desired, 6'h00);
        check6("rst_level", level, 6'h00);
        check1("rst_expecting", expecting_input, 1'b0);
        check1("rst_over", game_over, 1'b0);
        check1("rst_won", game_won, 1'b0);
        rst_n = 1'b1;
        tick();

        // Start, then reset while the first pattern is lit.
        start = 1'b1;
        tick();
        start = 1'b0;
        check6("first_level", level, 6'h01);
        tick();
        check6("first_led", led_pattern, 6'h0A);
        tick();
        rst_n = 1'b0;
        #1;
        check6("midreset_led", led_pattern, 6'h00);
        check6("midreset_level", level, 6'h00);
        tick();
        rst_n = 1'b1;
        tick();
        m_lfsr = SEED;
        m_nd = 6'h00;

        run_game(0, 0, 2, 2);
        run_game(2, 0, -1, 0);

        for (int g = 0; g < 6; g++) begin
            fr = $urandom_range(0, MAX_LEN);
            fs = (fr > 0) ? $urandom_range(0, fr - 1) : 0;
            sa = $urandom_range(0, 6) - 1;
            hr = $urandom_range(0, MAX_LEN);
            run_game(fr, fs, sa, hr);
        end

        // A fresh game from the end state restarts at level 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        check6("restart_level", level, 6'h01);
        check1("restart_over", game_over, 1'b0);
        check1("restart_won", game_won, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
